// File: rtl/pma_region_table.sv
`default_nettype none
// ============================================================================
// Module   : pma_region_table
// Brief    : Runtime-programmable PMA region table with lockable cfg port and
//            NrPorts independent single-cycle-latency lookup ports.
// Revision : 1.0
// ============================================================================
module pma_region_table #(
  parameter int unsigned                   NrRules     = 8,
  parameter int unsigned                   NrPorts     = 2,
  parameter int unsigned                   AddrWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0]  ResetBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0]  ResetLength = '0,
  parameter logic [NrRules*3-1:0]          ResetAttr   = '0,
  parameter logic [2:0]                    DefaultAttr = 3'b100,
  localparam int unsigned IdxWidth    = (NrRules > 1) ? $clog2(NrRules) : 1,
  localparam int unsigned CfgIdxWidth = $clog2(NrRules) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_req_i,
  input  logic                          cfg_we_i,
  input  logic [CfgIdxWidth-1:0]        cfg_idx_i,
  input  logic [1:0]                    cfg_field_i,
  input  logic [AddrWidth-1:0]          cfg_wdata_i,
  output logic                          cfg_rvalid_o,
  output logic [AddrWidth-1:0]          cfg_rdata_o,
  output logic                          cfg_err_o,
  output logic                          locked_o,
  input  logic [NrPorts-1:0]            lkp_valid_i,
  input  logic [NrPorts*AddrWidth-1:0]  lkp_addr_i,
  output logic [NrPorts-1:0]            lkp_valid_o,
  output logic [NrPorts-1:0]            lkp_hit_o,
  output logic [NrPorts*IdxWidth-1:0]   lkp_idx_o,
  output logic [NrPorts*3-1:0]          lkp_attr_o
);

  localparam logic [1:0] c_field_base = 2'd0;
  localparam logic [1:0] c_field_len  = 2'd1;
  localparam logic [1:0] c_field_attr = 2'd2;
  localparam logic [1:0] c_field_lock = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } cfg_state_t;

  logic [AddrWidth-1:0] r_base [NrRules];
  logic [AddrWidth-1:0] r_len  [NrRules];
  logic [2:0]           r_attr [NrRules];
  logic                 r_locked;

  cfg_state_t           r_state;
  logic [AddrWidth-1:0] r_rdata;
  logic                 r_err;

  logic                 w_idx_oob;
  logic                 w_err;
  logic                 w_commit;
  logic [IdxWidth-1:0]  w_sel;
  logic [AddrWidth-1:0] w_rdata;

  // Lock field ignores the index, so it can never be out of range.
  assign w_idx_oob = (cfg_field_i != c_field_lock) &&
                     (cfg_idx_i >= CfgIdxWidth'(NrRules));
  assign w_err     = w_idx_oob || (cfg_we_i && r_locked);
  assign w_commit  = cfg_req_i && cfg_we_i && !w_err;
  assign w_sel     = cfg_idx_i[IdxWidth-1:0];

  always_comb begin
    w_rdata = '0;
    if (!cfg_we_i && !w_err) begin
      case (cfg_field_i)
        c_field_base: w_rdata = r_base[w_sel];
        c_field_len:  w_rdata = r_len[w_sel];
        c_field_attr: w_rdata = AddrWidth'(r_attr[w_sel]);
        default:      w_rdata = AddrWidth'(r_locked);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        r_base[i] <= ResetBase[i*AddrWidth +: AddrWidth];
        r_len[i]  <= ResetLength[i*AddrWidth +: AddrWidth];
        r_attr[i] <= ResetAttr[i*3 +: 3];
      end
      r_locked <= 1'b0;
    end else if (w_commit) begin
      case (cfg_field_i)
        c_field_base: r_base[w_sel] <= cfg_wdata_i;
        c_field_len:  r_len[w_sel]  <= cfg_wdata_i;
        c_field_attr: r_attr[w_sel] <= cfg_wdata_i[2:0];
        default: begin
          if (cfg_wdata_i[0]) r_locked <= 1'b1;
        end
      endcase
    end
  end

  // A request arriving in RESP is simply accepted again: one access per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (cfg_req_i) begin
            r_state <= ST_RESP;
            r_rdata <= w_rdata;
            r_err   <= w_err;
          end else begin
            r_state <= ST_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_rvalid_o = (r_state == ST_RESP);
  assign cfg_rdata_o  = r_rdata;
  assign cfg_err_o    = r_err;
  assign locked_o     = r_locked;

  // Region end carried in AddrWidth+1 bits so a rule may end exactly at 2^AddrWidth.
  logic [AddrWidth:0] w_rule_end [NrRules];

  for (genvar r = 0; r < NrRules; r++) begin : g_rule_end
    assign w_rule_end[r] = {1'b0, r_base[r]} + {1'b0, r_len[r]};
  end

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic [AddrWidth-1:0] w_addr;
    logic [NrRules-1:0]   w_match;
    logic                 w_hit;
    logic [IdxWidth-1:0]  w_idx;
    logic [2:0]           w_attr;
    logic                 r_valid;
    logic                 r_hit;
    logic [IdxWidth-1:0]  r_idx;
    logic [2:0]           r_lkp_attr;

    assign w_addr = lkp_addr_i[p*AddrWidth +: AddrWidth];

    for (genvar r = 0; r < NrRules; r++) begin : g_match
      assign w_match[r] = (r_len[r] != '0) && (w_addr >= r_base[r]) &&
                          ({1'b0, w_addr} < w_rule_end[r]);
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
      w_hit  = 1'b0;
      w_idx  = '0;
      w_attr = DefaultAttr;
      for (int i = int'(NrRules) - 1; i >= 0; i--) begin
        if (w_match[i]) begin
          w_hit  = 1'b1;
          w_idx  = IdxWidth'(i);
          w_attr = r_attr[i];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid    <= 1'b0;
        r_hit      <= 1'b0;
        r_idx      <= '0;
        r_lkp_attr <= DefaultAttr;
      end else begin
        r_valid <= lkp_valid_i[p];
        if (lkp_valid_i[p]) begin
          r_hit      <= w_hit;
          r_idx      <= w_idx;
          r_lkp_attr <= w_attr;
        end
      end
    end

    assign lkp_valid_o[p]                     = r_valid;
    assign lkp_hit_o[p]                       = r_hit;
    assign lkp_idx_o[p*IdxWidth +: IdxWidth]  = r_idx;
    assign lkp_attr_o[p*3 +: 3]               = r_lkp_attr;
  end

endmodule
`default_nettype wire

// File: tb/tb_pma_region_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_pma_region_table
// Brief    : Directed and model-checked bench for pma_region_table.
// Revision : 1.0
// ============================================================================
module tb_pma_region_table;

  localparam int NR = 8;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int IW = 3;

  localparam logic [NR*AW-1:0] c_rst_base = {
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
    64'h0, 64'h1_0000, 64'h8000_0000};
  localparam logic [NR*AW-1:0] c_rst_len = {
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
    64'h1000, 64'h1_0000, 64'h4000_0000};
  localparam logic [NR*3-1:0] c_rst_attr = {
    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b011};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_req = 1'b0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_idx = '0;
  logic [1:0]        cfg_field = '0;
  logic [AW-1:0]     cfg_wdata = '0;
  logic              cfg_rvalid;
  logic [AW-1:0]     cfg_rdata;
  logic              cfg_err;
  logic              locked;
  logic [NP-1:0]     lkp_vin = '0;
  logic [NP*AW-1:0]  lkp_addr = '0;
  logic [NP-1:0]     lkp_vout;
  logic [NP-1:0]     lkp_hit;
  logic [NP*IW-1:0]  lkp_idx;
  logic [NP*3-1:0]   lkp_attr;

  int n_checks = 0;
  int n_fails  = 0;

  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [2:0]    m_attr [NR];

  always #5 clk = ~clk;

  pma_region_table #(
    .NrRules    (NR),
    .NrPorts    (NP),
    .AddrWidth  (AW),
    .ResetBase  (c_rst_base),
    .ResetLength(c_rst_len),
    .ResetAttr  (c_rst_attr),
    .DefaultAttr(3'b100)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_req_i   (cfg_req),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_field_i (cfg_field),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o (cfg_rdata),
    .cfg_err_o   (cfg_err),
    .locked_o    (locked),
    .lkp_valid_i (lkp_vin),
    .lkp_addr_i  (lkp_addr),
    .lkp_valid_o (lkp_vout),
    .lkp_hit_o   (lkp_hit),
    .lkp_idx_o   (lkp_idx),
    .lkp_attr_o  (lkp_attr)
  );

  task automatic check_val(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First-match search over the bench's copy of the table.
  function automatic void model_lookup(input logic [AW-1:0] a, output logic h,
                                       output logic [2:0] ix, output logic [2:0] at);
    logic [AW:0] lo, hi;
    h = 1'b0; ix = '0; at = 3'b100;
    for (int i = 0; i < NR; i++) begin
      lo = {1'b0, m_base[i]};
      hi = {1'b0, m_base[i]} + {1'b0, m_len[i]};
      if (!h && m_len[i] != '0 && {1'b0, a} >= lo && {1'b0, a} < hi) begin
        h = 1'b1; ix = i[2:0]; at = m_attr[i];
      end
    end
  endfunction

  task automatic cfg_op(input string tag, input logic we, input logic [3:0] idx,
                        input logic [1:0] field, input logic [AW-1:0] wdata,
                        input logic exp_err, input logic [AW-1:0] exp_rdata);
    cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = field; cfg_wdata = wdata;
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    check_val({tag, "_rvalid"}, AW'(cfg_rvalid), 64'd1);
    check_val({tag, "_err"},    AW'(cfg_err),    AW'(exp_err));
    check_val({tag, "_rdata"},  cfg_rdata,       exp_rdata);
  endtask

  task automatic lookup(input string tag, input int port, input logic [AW-1:0] addr,
                        input logic exp_hit, input logic [2:0] exp_idx, input logic [2:0] exp_attr);
    lkp_vin[port] = 1'b1;
    lkp_addr[port*AW +: AW] = addr;
    @(posedge clk); #1;
    lkp_vin = '0;
    check_val({tag, "_valid"}, AW'(lkp_vout[port]),        64'd1);
    check_val({tag, "_hit"},   AW'(lkp_hit[port]),         AW'(exp_hit));
    check_val({tag, "_idx"},   AW'(lkp_idx[port*IW +: IW]), AW'(exp_idx));
    check_val({tag, "_attr"},  AW'(lkp_attr[port*3 +: 3]),  AW'(exp_attr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra  [NP];
    logic          eh  [NP];
    logic [2:0]    ei  [NP];
    logic [2:0]    ea  [NP];

    for (int i = 0; i < NR; i++) begin
      m_base[i] = c_rst_base[i*AW +: AW];
      m_len[i]  = c_rst_len[i*AW +: AW];
      m_attr[i] = c_rst_attr[i*3 +: 3];
    end

    // Reset values, sampled while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_locked", AW'(locked),     64'd0);
    check_val("rst_rvalid", AW'(cfg_rvalid), 64'd0);
    check_val("rst_rdata",  cfg_rdata,       64'd0);
    check_val("rst_err",    AW'(cfg_err),    64'd0);
    check_val("rst_lvalid", AW'(lkp_vout),   64'd0);
    check_val("rst_hit",    AW'(lkp_hit),    64'd0);
    check_val("rst_idx",    AW'(lkp_idx),    64'd0);
    check_val("rst_attr",   AW'(lkp_attr),   64'h24);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset-loaded regions and their boundaries.
    lookup("dram_lo",  0, 64'h8000_0000, 1'b1, 3'd0, 3'b011);
    lookup("dram_hi",  1, 64'hBFFF_FFFF, 1'b1, 3'd0, 3'b011);
    lookup("dram_end", 0, 64'hC000_0000, 1'b0, 3'd0, 3'b100);
    lookup("rom_hi",   1, 64'h1_FFFF,    1'b1, 3'd1, 3'b010);
    lookup("rom_end",  1, 64'h2_0000,    1'b0, 3'd0, 3'b100);
    lookup("dm_hi",    0, 64'h0FFF,      1'b1, 3'd2, 3'b010);

    // Idle cycle: valid drops, result fields hold.
    lkp_addr[0 +: AW] = 64'h8000_0000;
    @(posedge clk); #1;
    check_val("hold_valid", AW'(lkp_vout[0]),     64'd0);
    check_val("hold_hit",   AW'(lkp_hit[0]),      64'd1);
    check_val("hold_idx",   AW'(lkp_idx[0 +: IW]), 64'd2);
    check_val("hold_attr",  AW'(lkp_attr[0 +: 3]), 64'h2);
    lookup("dm_end", 0, 64'h1000, 1'b0, 3'd0, 3'b100);

    // Overlapping rule 3 inside DRAM.
    cfg_op("w3_base", 1'b1, 4'd3, 2'd0, 64'h8000_0000, 1'b0, 64'd0);
    cfg_op("w3_len",  1'b1, 4'd3, 2'd1, 64'h1000,      1'b0, 64'd0);
    cfg_op("w3_attr", 1'b1, 4'd3, 2'd2, 64'h4,         1'b0, 64'd0);
    m_base[3] = 64'h8000_0000; m_len[3] = 64'h1000; m_attr[3] = 3'b100;
    @(posedge clk); #1;
    check_val("idle_rvalid", AW'(cfg_rvalid), 64'd0);
    cfg_op("r3_attr", 1'b0, 4'd3, 2'd2, 64'd0, 1'b0, 64'h4);
    lookup("overlap", 0, 64'h8000_0010, 1'b1, 3'd0, 3'b011);

    // Back-to-back reads, one response per cycle.
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 4'd1; cfg_field = 2'd0;
    @(posedge clk); #1;
    cfg_idx = 4'd2; cfg_field = 2'd1;
    check_val("b2b0_rvalid", AW'(cfg_rvalid), 64'd1);
    check_val("b2b0_rdata",  cfg_rdata,       64'h1_0000);
    @(posedge clk); #1;
    cfg_req = 1'b0;
    check_val("b2b1_rvalid", AW'(cfg_rvalid), 64'd1);
    check_val("b2b1_rdata",  cfg_rdata,       64'h1000);

    // Disable rule 0 in the same cycle as a lookup: old table wins.
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 2'd1; cfg_wdata = 64'd0;
    lkp_vin[0] = 1'b1; lkp_addr[0 +: AW] = 64'h8000_0000;
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0; lkp_vin = '0;
    m_len[0] = 64'd0;
    check_val("same_err",  AW'(cfg_err),         64'd0);
    check_val("same_hit",  AW'(lkp_hit[0]),      64'd1);
    check_val("same_idx",  AW'(lkp_idx[0 +: IW]), 64'd0);
    check_val("same_attr", AW'(lkp_attr[0 +: 3]), 64'h3);
    lookup("after_dis", 0, 64'h8000_0000, 1'b1, 3'd3, 3'b100);

    // Region ending exactly at the top of the address space.
    cfg_op("w4_base", 1'b1, 4'd4, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 64'd0);
    cfg_op("w4_len",  1'b1, 4'd4, 2'd1, 64'h1000,               1'b0, 64'd0);
    cfg_op("w4_attr", 1'b1, 4'd4, 2'd2, 64'h1,                  1'b0, 64'd0);
    m_base[4] = 64'hFFFF_FFFF_FFFF_F000; m_len[4] = 64'h1000; m_attr[4] = 3'b001;
    lookup("wrap_top", 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd4, 3'b001);
    lookup("wrap_below", 1, 64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 3'd0, 3'b100);

    // Lock behaviour.
    cfg_op("lock0", 1'b1, 4'd0, 2'd3, 64'd0, 1'b0, 64'd0);
    check_val("lock0_locked", AW'(locked), 64'd0);
    cfg_op("lock1", 1'b1, 4'd0, 2'd3, 64'd1, 1'b0, 64'd0);
    check_val("lock1_locked", AW'(locked), 64'd1);
    cfg_op("lkd_wbase", 1'b1, 4'd0, 2'd0, 64'h1234, 1'b1, 64'd0);
    cfg_op("lkd_rbase", 1'b0, 4'd0, 2'd0, 64'd0,    1'b0, 64'h8000_0000);
    cfg_op("lkd_rlock", 1'b0, 4'd0, 2'd3, 64'd0,    1'b0, 64'd1);
    cfg_op("lkd_relock", 1'b1, 4'd0, 2'd3, 64'd1,   1'b1, 64'd0);
    cfg_op("oob_read",  1'b0, 4'd8, 2'd0, 64'd0,    1'b1, 64'd0);
    cfg_op("lkd_wattr", 1'b1, 4'd2, 2'd2, 64'h7,    1'b1, 64'd0);
    lookup("lkd_dm", 0, 64'h0800, 1'b1, 3'd2, 3'b010);

    // Both ports every cycle against the model.
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) begin
        for (int p = 0; p < NP; p++) begin
          check_val($sformatf("rnd%0d_p%0d_valid", c, p), AW'(lkp_vout[p]), 64'd1);
          check_val($sformatf("rnd%0d_p%0d_hit", c, p),   AW'(lkp_hit[p]), AW'(eh[p]));
          check_val($sformatf("rnd%0d_p%0d_idx", c, p),   AW'(lkp_idx[p*IW +: IW]), AW'(ei[p]));
          check_val($sformatf("rnd%0d_p%0d_attr", c, p),  AW'(lkp_attr[p*3 +: 3]), AW'(ea[p]));
        end
      end
      if (c < 100) begin
        for (int p = 0; p < NP; p++) begin
          case ($urandom_range(0, 5))
            0: ra[p] = {$urandom, $urandom};
            1: ra[p] = 64'h7FFF_F000 + 64'($urandom_range(0, 32'h2000));
            2: ra[p] = 64'hBFFF_F000 + 64'($urandom_range(0, 32'h2000));
            3: ra[p] = 64'($urandom_range(0, 32'h2_1000));
            4: ra[p] = 64'hFFFF_FFFF_FFFF_E000 + 64'($urandom_range(0, 32'h1FFF));
            default: ra[p] = 64'h8000_0000 + 64'($urandom_range(0, 32'h1100));
          endcase
          model_lookup(ra[p], eh[p], ei[p], ea[p]);
          lkp_addr[p*AW +: AW] = ra[p];
        end
        lkp_vin = '1;
      end else begin
        lkp_vin = '0;
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
